// File: rtl/aud_recorder_mc.sv
// I2S capture engine: deserialises MSB-first words from BCLK and emits one-cycle SRAM write
// strobes, with left/right/stereo selection, pause/resume and stop-or-wrap at an end address.
module aud_recorder_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [1:0]        i_ch_sel,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_max_addr,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic              o_ch,
    output logic [ADDR_W:0]   o_len,
    output logic              o_wrap,
    output logic [2:0]        o_state
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArm     = 3'd1,
        StCapture = 3'd2,
        StPause   = 3'd3,
        StDone    = 3'd4
    } state_t;

    state_t              state_q, state_d, cap_state;
    logic                lrc_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, shift_in;
    logic                cur_ch_q, cur_ch_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ch_q, ch_d;
    logic                we_q, we_d;
    logic                wrap_q, wrap_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                slot_start, ch_hit, wr_end;

    always_comb begin
        state_d    = state_q;
        cap_state  = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        cur_ch_d   = cur_ch_q;
        data_d     = data_q;
        ch_d       = ch_q;
        we_d       = 1'b0;
        wrap_d     = 1'b0;
        addr_d     = addr_q;
        len_d      = len_q;
        slot_start = (i_lrc != lrc_q);
        ch_hit     = i_ch_sel[1] | (i_ch_sel[0] == i_lrc);
        shift_in   = {shift_q[DATA_W-2:0], i_data};
        wr_end     = we_q && (addr_q == i_max_addr);

        // Bookkeeping for the word strobed out during the current cycle
        if (we_q) begin
            len_d = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
            if (wr_end && i_loop) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (state_q == StArm) begin
            if (slot_start && ch_hit) begin
                cap_state = StCapture;
                cnt_d     = '0;
                cur_ch_d  = i_lrc;
            end
        end else if (state_q == StCapture) begin
            // A word-select toggle mid-word drops the partial word and opens a new slot
            if (slot_start) begin
                cnt_d     = '0;
                cur_ch_d  = i_lrc;
                cap_state = ch_hit ? StCapture : StArm;
            end else begin
                shift_d = shift_in;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    data_d    = shift_in;
                    ch_d      = cur_ch_q;
                    we_d      = 1'b1;
                    cap_state = StArm;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!i_stop && !i_pause && i_start) begin
                    state_d = StArm;
                    addr_d  = '0;
                    len_d   = '0;
                end
            end
            StDone: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (!i_pause && i_start) begin
                    state_d = StArm;
                    addr_d  = '0;
                    len_d   = '0;
                end
            end
            StPause: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (!i_pause && i_start) begin
                    state_d = StArm;
                end
            end
            StArm, StCapture: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (i_pause) begin
                    state_d = StPause;
                end else begin
                    state_d = cap_state;
                end
            end
            default: state_d = StIdle;
        endcase

        // Hitting the end address without looping ends the recording unless it was stopped
        if (wr_end && !i_loop && state_q != StIdle && state_q != StDone && state_d != StIdle) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            lrc_q    <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            cur_ch_q <= 1'b0;
            data_q   <= '0;
            ch_q     <= 1'b0;
            we_q     <= 1'b0;
            wrap_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            lrc_q    <= i_lrc;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            cur_ch_q <= cur_ch_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            we_q     <= we_d;
            wrap_q   <= wrap_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
        end
    end

    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_we      = we_q;
    assign o_ch      = ch_q;
    assign o_len     = len_q;
    assign o_wrap    = wrap_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_aud_recorder_mc.sv
// Directed bench for aud_recorder_mc: I2S slots are driven bit by bit, expected writes are
// queued when a slot is driven and popped whenever the DUT strobes o_we.
module tb_aud_recorder_mc;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 20;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_lrc;
    logic              i_data;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic [1:0]        i_ch_sel;
    logic              i_loop;
    logic [ADDR_W-1:0] i_max_addr;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_we;
    logic              o_ch;
    logic [ADDR_W:0]   o_len;
    logic              o_wrap;
    logic [2:0]        o_state;

    aud_recorder_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_lrc      (i_lrc),
        .i_data     (i_data),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .i_ch_sel   (i_ch_sel),
        .i_loop     (i_loop),
        .i_max_addr (i_max_addr),
        .o_address  (o_address),
        .o_data     (o_data),
        .o_we       (o_we),
        .o_ch       (o_ch),
        .o_len      (o_len),
        .o_wrap     (o_wrap),
        .o_state    (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ch;
        int unsigned       cyc;
    } exp_t;

    exp_t              sb[$];
    int                errors   = 0;
    int                checks   = 0;
    int unsigned       cyc      = 0;
    int                wrap_cnt = 0;
    logic              prev_we  = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCLK; outputs sampled on the falling edge
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
        if (o_wrap) wrap_cnt++;
        if (o_we) begin
            chk("we_back_to_back", {63'd0, prev_we}, 64'd0);
            chk("we_expected", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(o_address), 64'(e.addr));
                chk("wr_data", 64'(o_data), 64'(e.data));
                chk("wr_ch", {63'd0, o_ch}, {63'd0, e.ch});
                chk("wr_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_we = o_we;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 64'(o_state), 64'd0);
        chk({tag, "_we"}, {63'd0, o_we}, 64'd0);
        chk({tag, "_addr"}, 64'(o_address), 64'd0);
        chk({tag, "_data"}, 64'(o_data), 64'd0);
        chk({tag, "_ch"}, {63'd0, o_ch}, 64'd0);
        chk({tag, "_len"}, 64'(o_len), 64'd0);
        chk({tag, "_wrap"}, {63'd0, o_wrap}, 64'd0);
    endtask

    // Slot bit 0 is the I2S delay bit, bits 1..16 the word, later bits are filler ones
    task automatic send_slot(input logic lrc, input logic [DATA_W-1:0] word, input int len,
                             input bit exp_wr, input int pause_at = -1, input int start_at = -1,
                             input int stop_at = -1, input int rst_at = -1);
        exp_t e;
        if (exp_wr) begin
            e.addr = exp_addr;
            e.data = word;
            e.ch   = lrc;
            e.cyc  = cyc + 17;
            sb.push_back(e);
            exp_addr = (exp_addr == i_max_addr && i_loop) ? '0 : exp_addr + 1'b1;
        end
        for (int i = 0; i < len; i++) begin
            i_lrc   = lrc;
            i_data  = (i >= 1 && i <= 16) ? word[16 - i] : 1'b1;
            i_pause = (i == pause_at);
            i_start = (i == start_at);
            i_stop  = (i == stop_at);
            if (i == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                check_reset("rst_mid");
            end
            tick();
            i_rst_n = 1'b1;
        end
        i_pause = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start  = 1'b0;
        exp_addr = '0;
    endtask

    task automatic do_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic frame(input logic [DATA_W-1:0] l, input bit l_exp,
                         input logic [DATA_W-1:0] r, input bit r_exp);
        send_slot(1'b0, l, 32, l_exp);
        send_slot(1'b1, r, 32, r_exp);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_lrc      = 1'b1;
        i_data     = 1'b0;
        i_start    = 1'b0;
        i_pause    = 1'b0;
        i_stop     = 1'b0;
        i_ch_sel   = 2'b10;
        i_loop     = 1'b0;
        i_max_addr = '1;
        #1;
        check_reset("reset");
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();

        // Stereo capture
        do_start();
        chk("arm_state", 64'(o_state), 64'd1);
        frame(16'hA5C3, 1'b1, 16'h1234, 1'b1);
        chk("stereo_len", 64'(o_len), 64'd2);
        chk("stereo_addr", 64'(o_address), 64'd2);
        do_stop();
        chk("stop_state", 64'(o_state), 64'd0);
        chk("stop_len_kept", 64'(o_len), 64'd2);

        // Right only
        i_ch_sel = 2'b01;
        do_start();
        chk("start_clears_len", 64'(o_len), 64'd0);
        frame(16'h7777, 1'b0, 16'h0001, 1'b1);
        frame(16'h7777, 1'b0, 16'h8000, 1'b1);
        frame(16'h7777, 1'b0, 16'hFFFF, 1'b1);
        chk("right_len", 64'(o_len), 64'd3);
        do_stop();

        // End address without loop
        i_ch_sel   = 2'b10;
        i_max_addr = 20'd3;
        do_start();
        frame(16'h1001, 1'b1, 16'h1002, 1'b1);
        frame(16'h1003, 1'b1, 16'h1004, 1'b1);
        frame(16'h1005, 1'b0, 16'h1006, 1'b0);
        chk("noloop_state", 64'(o_state), 64'd4);
        chk("noloop_len", 64'(o_len), 64'd4);
        do_stop();
        chk("done_stop_state", 64'(o_state), 64'd0);

        // End address with loop
        i_loop   = 1'b1;
        wrap_cnt = 0;
        do_start();
        frame(16'h2001, 1'b1, 16'h2002, 1'b1);
        frame(16'h2003, 1'b1, 16'h2004, 1'b1);
        frame(16'h2005, 1'b1, 16'h2006, 1'b1);
        chk("loop_wraps", 64'(wrap_cnt), 64'd1);
        chk("loop_len", 64'(o_len), 64'd6);
        chk("loop_addr", 64'(o_address), 64'd2);
        do_stop();
        i_loop     = 1'b0;
        i_max_addr = '1;

        // Pause mid-word, resume three frames later
        do_start();
        send_slot(1'b0, 16'h1111, 32, 1'b1);
        send_slot(1'b1, 16'h2222, 32, 1'b0, 8);
        chk("pause_state", 64'(o_state), 64'd3);
        frame(16'h4444, 1'b0, 16'h5555, 1'b0);
        frame(16'h4444, 1'b0, 16'h5555, 1'b0);
        send_slot(1'b0, 16'h6666, 32, 1'b0, -1, 20);
        send_slot(1'b1, 16'h3333, 32, 1'b1);
        chk("resume_len", 64'(o_len), 64'd2);
        do_stop();

        // Stop on the LSB edge still writes; short slot is dropped
        i_ch_sel = 2'b00;
        do_start();
        send_slot(1'b0, 16'hBEEF, 32, 1'b1, -1, -1, 16);
        chk("lsb_stop_state", 64'(o_state), 64'd0);
        chk("lsb_stop_addr", 64'(o_address), 64'd1);
        chk("lsb_stop_len", 64'(o_len), 64'd1);
        i_ch_sel = 2'b10;
        do_start();
        send_slot(1'b1, 16'h9999, 10, 1'b0);
        send_slot(1'b0, 16'h5A5A, 32, 1'b1);
        chk("short_len", 64'(o_len), 64'd1);
        do_stop();

        // Asynchronous reset during capture
        do_start();
        send_slot(1'b1, 16'h0F0F, 32, 1'b1);
        send_slot(1'b0, 16'hC0DE, 32, 1'b0, -1, -1, -1, 6);
        chk("post_rst_state", 64'(o_state), 64'd0);
        chk("post_rst_len", 64'(o_len), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aud_recorder_mc.md
# aud_recorder_mc

Parametrised I2S capture engine, the next generation of the Lab3 audio recorder. It deserialises MSB-first I2S words of DATA_W bits from the codec bit clock and captures the left channel, the right channel, or both interleaved. Each completed word is presented with a one-cycle write strobe to the SRAM write path. A programmable end address either stops recording or wraps the buffer (loop mode).

## Interface
- DATA_W, 16: sample width in bits (8..32); bits beyond DATA_W in a channel slot are ignored
- ADDR_W, 20: address width
- i_clk  in  1  codec bit clock (BCLK); all flops on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_lrc  in  1  I2S word select: 0 = left slot, 1 = right slot
- i_data  in  1  I2S serial data
- i_start  in  1  level/pulse: start from IDLE or resume from PAUSE
- i_pause  in  1  pause request
- i_stop  in  1  stop request
- i_ch_sel  in  2  00 left only, 01 right only, 10/11 both (L then R)
- i_loop  in  1  1 = wrap at end address, 0 = stop at end address
- i_max_addr  in  ADDR_W  last writable address (inclusive)
- o_address  out  ADDR_W  write address, valid while o_we=1
- o_data  out  DATA_W  captured word, valid while o_we=1
- o_we  out  1  one-cycle write strobe
- o_ch  out  1  channel of o_data (0 = L, 1 = R)
- o_len  out  ADDR_W+1  words written since last start from IDLE (saturates at 2^ADDR_W)
- o_wrap  out  1  one-cycle pulse when address wraps to 0
- o_state  out  3  current FSM state (debug)

## Operation
- States: IDLE=0, ARM=1, CAPTURE=2, PAUSE=3, DONE=4.
- Control priority each cycle: i_stop > i_pause > i_start.
- IDLE: on i_start -> ARM; address and o_len cleared to 0.
- ARM: waits for a slot start of a selected channel.
  - Slot start is the edge where i_lrc differs from its registered copy (the I2S delay bit, not captured).
  - The next edge samples the MSB; enter CAPTURE.
- CAPTURE:
  - Shift i_data MSB-first, DATA_W bits.
  - On the edge sampling the LSB: load o_data, o_ch, o_address; assert o_we; return to ARM.
  - Partial word: an i_lrc toggle before DATA_W bits are captured discards the word. The toggle counts as a new slot start.
- Address update: on the edge after o_we, address +1 and o_len +1.
  - If the address written equals i_max_addr and i_loop=1: address -> 0, pulse o_wrap.
  - If the address written equals i_max_addr and i_loop=0: -> DONE.
- PAUSE: entered from ARM or CAPTURE; a partial word is discarded. i_start -> ARM, address retained. i_stop -> IDLE.
- DONE: no writes. i_stop -> IDLE; i_start -> ARM with address and o_len cleared.
- i_stop from any state -> IDLE. Address and o_len are retained until the next i_start.
- Simultaneous events:
  - A word completing on the same edge as i_stop or i_pause is still written (o_we=1).
  - Afterwards the FSM goes to IDLE or PAUSE; the address still increments.
- i_ch_sel is sampled only at slot start; changing it mid-word does not affect the word in progress.

## Timing
- Reset: state=IDLE, o_address=0, o_data=0, o_we=0, o_ch=0, o_len=0, o_wrap=0, shift reg=0, registered lrc=0.
- Reset mid-capture aborts immediately; no write is issued.
- Latency: o_we is high the cycle after the LSB sampling edge, i.e. DATA_W+1 edges after slot start.
- o_we is never high on two consecutive cycles.
- Minimum slot length is DATA_W+1 BCLK. Shorter slots never produce a write.
- o_address is stable for the whole o_we cycle; the SRAM writes on that cycle.

## Test plan
- Stereo, DATA_W=16, 32-BCLK slots, L=0xA5C3, R=0x1234, i_ch_sel=10 -> writes addr0=0xA5C3 (o_ch=0), addr1=0x1234 (o_ch=1), o_len=2.
- i_ch_sel=01, three frames R=0x0001/0x8000/0xFFFF -> three writes at addr 0..2, no left writes, each o_we exactly 1 cycle.
- i_max_addr=3, i_loop=0, 6 words -> writes addr 0..3, state DONE, o_len=4, no further o_we. Repeat with i_loop=1 -> addr sequence 0,1,2,3,0,1, o_wrap once, o_len=6.
- i_pause asserted at bit 7 of a word, i_start 3 frames later -> partial word discarded, next write uses next address, data from first full slot after resume.
- i_stop on the LSB edge of 0xBEEF -> 0xBEEF written, then IDLE; short 10-BCLK slot -> no write.
- i_rst_n low at bit 5 of capture -> all outputs reset values same cycle, state IDLE, no o_we.
